// File: rtl/kbd_matrix_ctrl.sv
// kbd_matrix_ctrl: PS/2 set-2 scancode stream to TRS-80 8x8 key matrix with Z80 row-select reads.
// Define KBD_MATRIX_EXT_EN to decode E0-prefixed arrow keys; otherwise E0 sequences are discarded.
module kbd_matrix_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_rd,
  output logic [7:0] kbd_data,
  output logic       key_event
);
  typedef enum logic [2:0] {
    IDLE, BRK, DISCARD
`ifdef KBD_MATRIX_EXT_EN
    , EXT, EXT_BRK
`endif
  } state_t;
`ifdef KBD_MATRIX_EXT_EN
  localparam state_t E0_NEXT = EXT;
`else
  localparam state_t E0_NEXT = DISCARD;
`endif
  state_t      state, nxt;
  logic [63:0] matrix;
  logic [15:0] cnt;
  logic [6:0]  loc;
  logic        upd, val, hit;
  logic [7:0]  rows_or;
  // Map entries are {valid, row, bit}; octal literal 1rb reads as row r bit b.
  function automatic logic [6:0] base_map(input logic [7:0] c);
    case (c)
      8'h54: base_map = 7'o100; 8'h1C: base_map = 7'o101; 8'h32: base_map = 7'o102; 8'h21: base_map = 7'o103;
      8'h23: base_map = 7'o104; 8'h24: base_map = 7'o105; 8'h2B: base_map = 7'o106; 8'h34: base_map = 7'o107;
      8'h33: base_map = 7'o110; 8'h43: base_map = 7'o111; 8'h3B: base_map = 7'o112; 8'h42: base_map = 7'o113;
      8'h4B: base_map = 7'o114; 8'h3A: base_map = 7'o115; 8'h31: base_map = 7'o116; 8'h44: base_map = 7'o117;
      8'h4D: base_map = 7'o120; 8'h15: base_map = 7'o121; 8'h2D: base_map = 7'o122; 8'h1B: base_map = 7'o123;
      8'h2C: base_map = 7'o124; 8'h3C: base_map = 7'o125; 8'h2A: base_map = 7'o126; 8'h1D: base_map = 7'o127;
      8'h22: base_map = 7'o130; 8'h35: base_map = 7'o131; 8'h1A: base_map = 7'o132;
      8'h45: base_map = 7'o140; 8'h16: base_map = 7'o141; 8'h1E: base_map = 7'o142; 8'h26: base_map = 7'o143;
      8'h25: base_map = 7'o144; 8'h2E: base_map = 7'o145; 8'h36: base_map = 7'o146; 8'h3D: base_map = 7'o147;
      8'h3E: base_map = 7'o150; 8'h46: base_map = 7'o151; 8'h52: base_map = 7'o152; 8'h4C: base_map = 7'o153;
      8'h41: base_map = 7'o154; 8'h4E: base_map = 7'o155; 8'h49: base_map = 7'o156; 8'h4A: base_map = 7'o157;
      8'h5A: base_map = 7'o160; 8'h05: base_map = 7'o161; 8'h76: base_map = 7'o162; 8'h29: base_map = 7'o167;
      8'h12: base_map = 7'o170; 8'h59: base_map = 7'o170;
      default: base_map = 7'o000;
    endcase
  endfunction
`ifdef KBD_MATRIX_EXT_EN
  function automatic logic [6:0] ext_map(input logic [7:0] c);
    case (c)
      8'h75: ext_map = 7'o163; 8'h72: ext_map = 7'o164; 8'h6B: ext_map = 7'o165; 8'h74: ext_map = 7'o166;
      default: ext_map = 7'o000;
    endcase
  endfunction
`endif
  always_comb begin
    nxt = state;
    upd = 1'b0;
    val = 1'b0;
    loc = base_map(rx_data);
    if (rx_valid) begin
      case (state)
        IDLE: begin
          nxt = rx_data == 8'hF0 ? BRK : rx_data == 8'hE0 ? E0_NEXT : IDLE;
          upd = !(rx_data inside {8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'hFE, 8'hE1});
          val = 1'b1;
        end
        BRK: begin
          upd = !(rx_data inside {8'hF0, 8'hE0});
          nxt = upd ? IDLE : BRK;
        end
        DISCARD: nxt = rx_data == 8'hF0 ? DISCARD : IDLE;
`ifdef KBD_MATRIX_EXT_EN
        EXT: begin
          nxt = rx_data == 8'hF0 ? EXT_BRK : IDLE;
          upd = rx_data != 8'hF0;
          val = 1'b1;
          loc = ext_map(rx_data);
        end
        EXT_BRK: begin
          nxt = IDLE;
          upd = 1'b1;
          loc = ext_map(rx_data);
        end
`endif
        default: nxt = IDLE;
      endcase
    end else if (state != IDLE && cnt == TIMEOUT_CYCLES - 16'd1) begin
      nxt = IDLE;
    end
    hit = upd && loc[6] && matrix[loc[5:0]] != val;
  end
  always_comb begin
    rows_or = '0;
    for (int r = 0; r < 8; r++) rows_or = rows_or | (cpu_addr[r] ? matrix[r*8 +: 8] : 8'h00);
  end
  // Reads sample the matrix before this cycle's update, so a coincident scancode is not visible yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      matrix    <= '0;
      cnt       <= '0;
      kbd_data  <= '0;
      key_event <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= (rx_valid || state == IDLE) ? 16'd0 : cnt + 16'd1;
      key_event <= hit;
      if (hit) matrix[loc[5:0]] <= val;
      if (cpu_rd) kbd_data <= rows_or;
    end
  end
endmodule

// File: tb/tb_kbd_matrix_ctrl.sv
// tb_kbd_matrix_ctrl: randomized and directed checks of kbd_matrix_ctrl against a scancode-level key model.
module tb_kbd_matrix_ctrl;
  localparam int T = 8;
`ifdef KBD_MATRIX_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset, rx_valid, cpu_rd, key_event;
  logic [7:0] rx_data, cpu_addr, kbd_data;
  int checks = 0, errors = 0;
  logic [7:0] mat [8];
  logic [7:0] rows [8][8];
  int base_loc [256];
  int ext_loc [256];
  int mode, idle;

  always #5 clk = ~clk;

  kbd_matrix_ctrl #(.TIMEOUT_CYCLES(16'(T))) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .kbd_data(kbd_data), .key_event(key_event)
  );

  // Keyboard layout as the TRS-80 rows list it; 0 marks an empty position.
  function automatic void init_maps();
    rows = '{'{8'h54, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34},
             '{8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44},
             '{8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D},
             '{8'h22, 8'h35, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
             '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D},
             '{8'h3E, 8'h46, 8'h52, 8'h4C, 8'h41, 8'h4E, 8'h49, 8'h4A},
             '{8'h5A, 8'h05, 8'h76, 8'h00, 8'h00, 8'h00, 8'h00, 8'h29},
             '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    for (int i = 0; i < 256; i++) begin base_loc[i] = -1; ext_loc[i] = -1; end
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 8; b++)
        if (rows[r][b] != 8'h00) base_loc[rows[r][b]] = r * 8 + b;
    base_loc[8'h59] = 56;
    if (EXT_EN) begin
      ext_loc[8'h75] = 51; ext_loc[8'h72] = 52; ext_loc[8'h6B] = 53; ext_loc[8'h74] = 54;
    end
  endfunction

  function automatic bit set_key(int loc, bit v);
    bit old;
    if (loc < 0) return 1'b0;
    old = mat[loc / 8][loc % 8];
    mat[loc / 8][loc % 8] = v;
    return old != v;
  endfunction

  // mode: 0 none pending, 1 break, 2 extended, 3 extended break, 4 discarding an E0 sequence
  function automatic bit model(logic [7:0] c);
    bit p = 1'b0;
    if (mode != 0 && idle >= T) mode = 0;
    case (mode)
      0: if (c == 8'hF0) mode = 1;
         else if (c == 8'hE0) mode = EXT_EN ? 2 : 4;
         else if (!(c inside {8'hAA, 8'hFA, 8'hFE, 8'hE1})) p = set_key(base_loc[c], 1'b1);
      1: if (!(c inside {8'hE0, 8'hF0})) begin p = set_key(base_loc[c], 1'b0); mode = 0; end
      2: if (c == 8'hF0) mode = 3; else begin p = set_key(ext_loc[c], 1'b1); mode = 0; end
      3: begin p = set_key(ext_loc[c], 1'b0); mode = 0; end
      default: if (c != 8'hF0) mode = 0;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] exp_read(logic [7:0] a);
    logic [7:0] v = 8'h00;
    for (int r = 0; r < 8; r++) if (a[r]) v |= mat[r];
    return v;
  endfunction

  task automatic send(input logic [7:0] c, output logic obs, output logic exp);
    exp = model(c);
    idle = 0;
    rx_valid = 1'b1;
    rx_data = c;
    @(posedge clk); @(negedge clk);
    rx_valid = 1'b0;
    obs = key_event;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); idle++; end
  endtask

  task automatic read(input logic [7:0] a, output logic [7:0] obs);
    cpu_rd = 1'b1;
    cpu_addr = a;
    @(posedge clk); @(negedge clk);
    cpu_rd = 1'b0;
    idle++;
    obs = kbd_data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h1C;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    rx_valid = 1'b0;
    for (int r = 0; r < 8; r++) mat[r] = 8'h00;
    mode = 0;
    idle = 0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    if (kbd_data !== 8'h00) begin errors++; $display("FAIL reset_kbd_data got %h want 00", kbd_data); end
    checks++;
    if (key_event !== 1'b0) begin errors++; $display("FAIL reset_key_event got %b want 0", key_event); end
    checks++;
    read(8'hFF, d);
    if (d !== 8'h00) begin errors++; $display("FAIL reset_rx_discard got %h want 00", d); end
    checks++;
  endtask

  task automatic test_make_break();
    logic o, e;
    logic [7:0] d;
    send(8'h1C, o, e);
    if (o !== 1'b1) begin errors++; $display("FAIL make_pulse got %b want 1", o); end
    checks++;
    idle_cycles(1);
    if (key_event !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", key_event); end
    checks++;
    read(8'h01, d);
    if (d !== 8'h02) begin errors++; $display("FAIL make_read got %h want 02", d); end
    checks++;
    send(8'hF0, o, e);
    if (o !== 1'b0) begin errors++; $display("FAIL prefix_pulse got %b want 0", o); end
    checks++;
    send(8'h1C, o, e);
    if (o !== 1'b1) begin errors++; $display("FAIL break_pulse got %b want 1", o); end
    checks++;
    read(8'h01, d);
    if (d !== 8'h00) begin errors++; $display("FAIL break_read got %h want 00", d); end
    checks++;
  endtask

  task automatic test_multi_row();
    logic o, e;
    logic [7:0] d;
    send(8'h12, o, e);
    send(8'h5A, o, e);
    read(8'hC0, d);
    if (d !== 8'h01) begin errors++; $display("FAIL rows_or got %h want 01", d); end
    checks++;
    read(8'h00, d);
    if (d !== 8'h00) begin errors++; $display("FAIL no_rows got %h want 00", d); end
    checks++;
    read(8'h80, d);
    if (d !== 8'h01) begin errors++; $display("FAIL shift_row got %h want 01", d); end
    checks++;
    send(8'hF0, o, e); send(8'h12, o, e);
    send(8'hF0, o, e); send(8'h5A, o, e);
    read(8'hC0, d);
    if (d !== 8'h00) begin errors++; $display("FAIL rows_released got %h want 00", d); end
    checks++;
  endtask

  task automatic test_ext();
    logic o, e;
    logic [7:0] d;
    send(8'hE0, o, e);
    send(8'h75, o, e);
    if (o !== EXT_EN) begin errors++; $display("FAIL ext_make_pulse got %b want %b", o, EXT_EN); end
    checks++;
    read(8'h40, d);
    if (d !== (EXT_EN ? 8'h08 : 8'h00)) begin errors++; $display("FAIL ext_make_read got %h want %h", d, EXT_EN ? 8'h08 : 8'h00); end
    checks++;
    send(8'hE0, o, e); send(8'hF0, o, e);
    send(8'h75, o, e);
    if (o !== EXT_EN) begin errors++; $display("FAIL ext_break_pulse got %b want %b", o, EXT_EN); end
    checks++;
    send(8'h1C, o, e);
    if (o !== 1'b1) begin errors++; $display("FAIL after_ext_idle got %b want 1", o); end
    checks++;
    send(8'hF0, o, e); send(8'h1C, o, e);
    read(8'hFF, d);
    if (d !== 8'h00) begin errors++; $display("FAIL ext_clean got %h want 00", d); end
    checks++;
  endtask

  task automatic test_timeout();
    logic o, e;
    logic [7:0] d;
    send(8'h29, o, e);
    send(8'hF0, o, e);
    idle_cycles(T - 1);
    send(8'h29, o, e);
    if (o !== 1'b1) begin errors++; $display("FAIL before_timeout_break got %b want 1", o); end
    checks++;
    read(8'h40, d);
    if (d !== 8'h00) begin errors++; $display("FAIL before_timeout_read got %h want 00", d); end
    checks++;
    send(8'hF0, o, e);
    idle_cycles(T);
    send(8'h29, o, e);
    if (o !== 1'b1) begin errors++; $display("FAIL timeout_make got %b want 1", o); end
    checks++;
    read(8'h40, d);
    if (d !== 8'h80) begin errors++; $display("FAIL timeout_read got %h want 80", d); end
    checks++;
    send(8'hF0, o, e); send(8'h29, o, e);
  endtask

  task automatic test_idempotent();
    logic o, e;
    send(8'h1C, o, e);
    send(8'h1C, o, e);
    if (o !== 1'b0) begin errors++; $display("FAIL repeat_make got %b want 0", o); end
    checks++;
    send(8'hF0, o, e); send(8'h1C, o, e);
    send(8'hF0, o, e); send(8'h1C, o, e);
    if (o !== 1'b0) begin errors++; $display("FAIL repeat_break got %b want 0", o); end
    checks++;
    send(8'h0E, o, e);
    if (o !== 1'b0) begin errors++; $display("FAIL unmapped got %b want 0", o); end
    checks++;
    send(8'hAA, o, e);
    if (o !== 1'b0) begin errors++; $display("FAIL ignored_code got %b want 0", o); end
    checks++;
  endtask

  task automatic test_coincident();
    logic p;
    logic [7:0] d;
    p = model(8'h29);
    idle = 0;
    rx_valid = 1'b1; rx_data = 8'h29; cpu_rd = 1'b1; cpu_addr = 8'h40;
    @(posedge clk); @(negedge clk);
    rx_valid = 1'b0; cpu_rd = 1'b0;
    if (kbd_data !== 8'h00) begin errors++; $display("FAIL coincident_read got %h want 00", kbd_data); end
    checks++;
    if (key_event !== p) begin errors++; $display("FAIL coincident_pulse got %b want %b", key_event, p); end
    checks++;
    read(8'h40, d);
    if (d !== 8'h80) begin errors++; $display("FAIL post_coincident got %h want 80", d); end
    checks++;
  endtask

  task automatic test_hold();
    logic o, e;
    logic [7:0] d;
    send(8'h1C, o, e);
    read(8'h01, d);
    cpu_addr = 8'hFF;
    send(8'h32, o, e);
    idle_cycles(2);
    if (kbd_data !== 8'h02) begin errors++; $display("FAIL hold got %h want 02", kbd_data); end
    checks++;
  endtask

  task automatic test_mid_reset();
    logic o, e;
    logic [7:0] d;
    send(8'hE0, o, e);
    do_reset();
    send(8'h1C, o, e);
    if (o !== 1'b1) begin errors++; $display("FAIL mid_reset_pulse got %b want 1", o); end
    checks++;
    read(8'h01, d);
    if (d !== 8'h02) begin errors++; $display("FAIL mid_reset_row0 got %h want 02", d); end
    checks++;
  endtask

  task automatic test_random();
    logic o, e;
    logic [7:0] c, d, a;
    int k, r, b;
    logic [7:0] misc [8] = '{8'hAA, 8'hFA, 8'hFE, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      if (k == 9) begin
        a = 8'($urandom);
        read(a, d);
        if (d !== exp_read(a)) begin errors++; $display("FAIL rand_read addr %h got %h want %h", a, d, exp_read(a)); end
        checks++;
      end else begin
        if (k <= 4) begin
          c = 8'h00;
          while (c == 8'h00) begin r = $urandom_range(0, 7); b = $urandom_range(0, 7); c = rows[r][b]; end
        end else c = k == 5 ? 8'hF0 : k == 6 ? 8'hE0 : k == 7 ? misc[$urandom_range(0, 7)] : 8'($urandom);
        send(c, o, e);
        if (o !== e) begin errors++; $display("FAIL rand_pulse code %h got %b want %b", c, o, e); end
        checks++;
        idle_cycles($urandom_range(0, 7) == 0 ? T + $urandom_range(0, 1) - 1 : $urandom_range(0, 2));
      end
    end
    for (int r2 = 0; r2 < 8; r2++) begin
      read(8'(1 << r2), d);
      if (d !== mat[r2]) begin errors++; $display("FAIL rand_row %0d got %h want %h", r2, d, mat[r2]); end
      checks++;
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cpu_rd = 1'b0; cpu_addr = 8'h00;
    mode = 0; idle = 0;
    for (int r = 0; r < 8; r++) mat[r] = 8'h00;
    init_maps();
    @(negedge clk);
    test_reset();
    test_make_break();
    test_multi_row();
    test_ext();
    test_timeout();
    test_idempotent();
    test_coincident();
    test_hold();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kbd_matrix_ctrl.md
KBD_MATRIX_CTRL -- requirements
Module: kbd_matrix_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, meaning the maximum idle cycles allowed inside a prefix sequence.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  scancode byte from the PS/2 decoder.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid only in that cycle.
REQ-006 SHALL have port cpu_addr  input  8  Z80 A7..A0 of a 0x38xx keyboard read; bit n selects matrix row n.
REQ-007 SHALL have port cpu_rd  input  1  keyboard-page read strobe.
REQ-008 SHALL have port kbd_data  output  8  registered OR of the selected rows.
REQ-009 SHALL have port key_event  output  1  one-cycle pulse on any change to the matrix.

Function
REQ-010 SHALL hold an 8x8 key matrix; row r bit c is 1 while that key is held.
REQ-011 SHALL decode the byte stream with FSM states IDLE, BRK, EXT, EXT_BRK, DISCARD.
REQ-012 In IDLE: 0xF0 -> BRK; 0xE0 -> EXT; 0xAA, 0xFA, 0xFE, 0xE1 ignored (stay IDLE); any other code sets its mapped bit.
REQ-013 In BRK: a code clears its mapped bit -> IDLE; 0xE0/0xF0 received in BRK SHALL be ignored (stay BRK).
REQ-014 In EXT: 0xF0 -> EXT_BRK; another code sets its extended-mapped bit -> IDLE.
REQ-015 In EXT_BRK: a code clears its extended-mapped bit -> IDLE.
REQ-016 Unmapped codes SHALL leave the matrix unchanged, return to IDLE and not pulse key_event.
REQ-017 Base map SHALL be the TRS-80 layout: row0 @ A-G; row1 H-O; row2 P-W; row3 X Y Z; row4 0-7; row5 8 9 : ; , - . /; row6 ENTER CLEAR BREAK UP DOWN LEFT RIGHT SPACE; row7 bit0 SHIFT.
REQ-018 Fixed base entries: 0x1C->r0b1, 0x5A->r6b0, 0x76(Esc)->r6b2 BREAK, 0x29->r6b7, 0x12 and 0x59->r7b0, 0x45->r4b0.
REQ-019 Extended entries: E0 75->r6b3, E0 72->r6b4, E0 6B->r6b5, E0 74->r6b6.
REQ-020 The matrix SHALL update on the cycle after rx_valid; key_event SHALL pulse in that same cycle only if a bit value actually changed.
REQ-021 While cpu_rd=1, kbd_data SHALL load the bitwise OR of rows whose cpu_addr bit is 1; cpu_addr=0 gives 0x00; latency 1 cycle; kbd_data SHALL hold when cpu_rd=0.
REQ-022 When rx_valid and cpu_rd coincide, the read SHALL return the pre-update matrix.
REQ-023 In BRK, EXT, EXT_BRK or DISCARD, TIMEOUT_CYCLES cycles without rx_valid SHALL return the FSM to IDLE with no matrix change; the counter SHALL restart on each rx_valid.
REQ-024 Make codes for keys already set and break codes for keys already clear SHALL be idempotent (no key_event).

Reset
REQ-025 Reset SHALL force the FSM to IDLE, clear the matrix, the timeout counter, kbd_data (0x00) and key_event (0), including mid-sequence.
REQ-026 rx_valid asserted during reset SHALL be discarded.

Configuration
REQ-027 Macro KBD_MATRIX_EXT_EN SHALL compile extended-key (E0) mapping in.
REQ-028 With KBD_MATRIX_EXT_EN defined, REQ-014, REQ-015 and REQ-019 SHALL apply.
REQ-029 Without KBD_MATRIX_EXT_EN, 0xE0 in IDLE SHALL enter DISCARD. In DISCARD, 0xF0 is absorbed (stay DISCARD) and the next non-F0 byte SHALL return to IDLE with no matrix change. EXT and EXT_BRK are absent.

Verification
REQ-030 Send 1C, then read cpu_addr=0x01 -> kbd_data=0x02 and one key_event pulse; then F0 1C and read -> 0x00 with one more pulse.
REQ-031 Hold 12 and 5A, then read cpu_addr=0xC0 -> kbd_data=0x01; read cpu_addr=0x00 -> 0x00.
REQ-032 Send E0 75, then read 0x40: with the macro -> 0x08; without it -> 0x00 and no key_event.
REQ-033 Send F0 and wait TIMEOUT_CYCLES idle cycles, then send 29 -> the SPACE bit is set, because the code is treated as a make.
REQ-034 Send E0, assert reset, then send 1C -> row0=0x02 and the FSM is in IDLE.
REQ-035 Apply rx_valid(29) and cpu_rd(addr 0x40) in the same cycle -> kbd_data=0x00; the next read returns 0x80.
